// File: rtl/exc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_seq_ctrl
// Purpose  : Exception/interrupt sequencing controller with the CP0 register
//            file for a 5-stage MIPS pipeline. It arbitrates hardware
//            interrupts, M-stage exceptions, eret and mtc0. It latches
//            EPC/Cause/SR, holds flush for DRAIN_CYCLES cycles and then issues
//            a single PC redirect to the handler or to EPC.
// Ports    : clk, reset (async, active high)
//            hwint[HWINT_W]          level-sensitive interrupt requests
//            exc_valid, exc_code,
//            pc_m, bd_m, eret_m      M-stage event information
//            cp0_we, cp0_addr,
//            cp0_wdata, cp0_rdata    mtc0 / mfc0 access
//            flush, redirect_valid,
//            redirect_pc, busy,
//            epc_out                 pipeline control and status
// Options  : EXC_COUNT_EN adds a 32-bit take counter at CP0 address 16.
// Revision : 1.0 - initial release
// ============================================================================
module exc_seq_ctrl #(
    parameter int          HWINT_W      = 6,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] PRID_VAL     = 32'h0000_2019
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [HWINT_W-1:0] hwint,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic [31:0]        pc_m,
    input  logic               bd_m,
    input  logic               eret_m,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               busy,
    output logic [31:0]        epc_out
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    localparam logic [2:0] C_CNT_INIT = 3'(DRAIN_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [HWINT_W-1:0]  r_im;
    logic                r_exl;
    logic                r_ie;
    logic                r_bd;
    logic [HWINT_W-1:0]  r_ip;
    logic [4:0]          r_exccode;
    logic [31:0]         r_epc;
    logic [31:0]         r_target;
    logic [2:0]          r_cnt;
`ifdef EXC_COUNT_EN
    logic [31:0]         r_count;
`endif

    logic        w_idle;
    logic        w_int_req;
    logic        w_take;
    logic        w_eret;
    logic        w_wr;
    logic [31:0] w_epc_next;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_unused_wdata;

    assign w_idle    = (r_state == S_IDLE);
    assign w_int_req = r_ie & ~r_exl & (|(hwint & r_im));
    assign w_take    = w_idle & (w_int_req | (exc_valid & ~r_exl));
    // eret outranks mtc0; both lose to a take in the same cycle.
    assign w_eret    = w_idle & ~w_take & eret_m;
    assign w_wr      = w_idle & ~w_take & ~eret_m & cp0_we;

    // A delay-slot instruction restarts at its branch.
    assign w_epc_next = (bd_m ? (pc_m - 32'd4) : pc_m) & ~32'd3;

    assign w_sr    = ({{(32-HWINT_W){1'b0}}, r_im} << 10) | {30'b0, r_exl, r_ie};
    assign w_cause = {r_bd, 31'b0}
                   | ({{(32-HWINT_W){1'b0}}, r_ip} << 10)
                   | {25'b0, r_exccode, 2'b00};

    assign epc_out        = r_epc;
    // Only a subset of the mtc0 data bits lands in architectural state.
    assign w_unused_wdata = ^cp0_wdata;

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            5'd12:   cp0_rdata = w_sr;
            5'd13:   cp0_rdata = w_cause;
            5'd14:   cp0_rdata = r_epc;
            5'd15:   cp0_rdata = PRID_VAL;
`ifdef EXC_COUNT_EN
            5'd16:   cp0_rdata = r_count;
`endif
            default: cp0_rdata = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and pipeline-control outputs
    always_comb begin
        w_state_next   = r_state;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        busy           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take || w_eret) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_next = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                flush          = 1'b1;
                busy           = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = r_target;
                w_state_next   = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // CP0 registers, drain counter and redirect target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
            r_target  <= 32'd0;
            r_cnt     <= 3'd0;
`ifdef EXC_COUNT_EN
            r_count   <= 32'd0;
`endif
        end else begin
            r_ip <= hwint;
            if (w_take) begin
                r_exl     <= 1'b1;
                r_epc     <= w_epc_next;
                r_bd      <= bd_m;
                r_exccode <= w_int_req ? 5'd0 : exc_code;
                r_target  <= HANDLER_ADDR;
                r_cnt     <= C_CNT_INIT;
`ifdef EXC_COUNT_EN
                r_count   <= r_count + 32'd1;
`endif
            end else if (w_eret) begin
                r_exl    <= 1'b0;
                r_target <= r_epc;
                r_cnt    <= C_CNT_INIT;
            end else if (w_wr) begin
                case (cp0_addr)
                    5'd12: begin
                        r_im  <= cp0_wdata[10 +: HWINT_W];
                        r_exl <= cp0_wdata[1];
                        r_ie  <= cp0_wdata[0];
                    end
                    5'd14: r_epc <= cp0_wdata & ~32'd3;
`ifdef EXC_COUNT_EN
                    5'd16: r_count <= 32'd0;
`endif
                    default: ;
                endcase
            end else if ((r_state == S_FLUSH) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_seq_ctrl
// Purpose  : Self-checking bench for exc_seq_ctrl: a table of mtc0/mfc0
//            vectors plus directed interrupt/exception/eret/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hwint;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        eret_m;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [31:0] epc_out;

    int checks   = 0;
    int failures = 0;

    exc_seq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .hwint          (hwint),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .pc_m           (pc_m),
        .bd_m           (bd_m),
        .eret_m         (eret_m),
        .cp0_we         (cp0_we),
        .cp0_addr       (cp0_addr),
        .cp0_wdata      (cp0_wdata),
        .cp0_rdata      (cp0_rdata),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .epc_out        (epc_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [5:0]  hw;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we    = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
        step();
        cp0_we    = 1'b0;
        cp0_wdata = 32'd0;
    endtask

    // Called in the cycle right after the event edge (or later, with fewer
    // remaining flush cycles). Counts flush-only cycles, then checks the
    // redirect cycle and the return to idle.
    task automatic watch_seq(input string nm, input int exp_n, input logic [31:0] exp_pc);
        int n = 0;
        while (flush && !redirect_valid && n < 20) begin
            n++;
            step();
        end
        chk({nm, "_flush_cycles"}, 32'(n), 32'(exp_n));
        chk({nm, "_redir_valid"}, {31'b0, redirect_valid}, 32'd1);
        chk({nm, "_redir_flush"}, {31'b0, flush}, 32'd1);
        chk({nm, "_redir_pc"}, redirect_pc, exp_pc);
        step();
        chk({nm, "_idle_busy"}, {31'b0, busy}, 32'd0);
        chk({nm, "_idle_redir"}, {31'b0, redirect_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;

        //            we    addr   wdata          hw         raddr  exp
        vecs[0] = '{1'b1, 5'd12, 32'hFFFF_FFFF, 6'b000000, 5'd12, 32'h0000_FC03};
        vecs[1] = '{1'b1, 5'd12, 32'h0000_0000, 6'b000000, 5'd12, 32'h0000_0000};
        vecs[2] = '{1'b1, 5'd14, 32'h1234_5677, 6'b000000, 5'd14, 32'h1234_5674};
        vecs[3] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 6'b000000, 5'd13, 32'h0000_0000};
        vecs[4] = '{1'b1, 5'd15, 32'h0000_DEAD, 6'b000000, 5'd15, 32'h0000_2019};
        vecs[5] = '{1'b1, 5'd3,  32'hFFFF_FFFF, 6'b000000, 5'd3,  32'h0000_0000};
        vecs[6] = '{1'b0, 5'd0,  32'h0000_0000, 6'b000000, 5'd16, 32'h0000_0000};
        vecs[7] = '{1'b1, 5'd14, 32'h0000_0000, 6'b000000, 5'd14, 32'h0000_0000};
        vecs[8] = '{1'b0, 5'd0,  32'h0000_0000, 6'b101000, 5'd13, 32'h0000_A000};
        vecs[9] = '{1'b0, 5'd0,  32'h0000_0000, 6'b000000, 5'd13, 32'h0000_0000};

        reset = 1'b1;
        hwint = '0; exc_valid = 0; exc_code = '0; pc_m = '0; bd_m = 0;
        eret_m = 0; cp0_we = 0; cp0_addr = '0; cp0_wdata = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        rd(5'd12, d); chk("rst_sr", d, 32'd0);
        rd(5'd13, d); chk("rst_cause", d, 32'd0);
        rd(5'd14, d); chk("rst_epc", d, 32'd0);
        rd(5'd15, d); chk("rst_prid", d, 32'h0000_2019);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_redir", {31'b0, redirect_valid}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // ---------------- table: mtc0 / mfc0 ----------------
        for (int i = 0; i < 10; i++) begin
            cp0_we    = vecs[i].we;
            cp0_addr  = vecs[i].addr;
            cp0_wdata = vecs[i].wdata;
            hwint     = vecs[i].hw;
            step();
            cp0_we    = 1'b0;
            rd(vecs[i].raddr, d);
            chk($sformatf("vec%0d_rd%0d", i, vecs[i].raddr), d, vecs[i].exp);
            chk($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd0);
        end

        // ---------------- interrupt take ----------------
        pc_m = 32'h0000_1000;
        hwint = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);          // take happens on the next edge
        chk("int_pre_busy", {31'b0, busy}, 32'd0);
        step();
        rd(5'd12, d); chk("int_sr", d, 32'h0000_0403);
        rd(5'd13, d); chk("int_cause", d, 32'h0000_0400);
        chk("int_epc", epc_out, 32'h0000_1000);
        watch_seq("int", 3, 32'h0000_4180);
        hwint = '0;
        mtc0(5'd12, 32'h0000_0000);

        // ---------------- exception in delay slot ----------------
        exc_valid = 1; exc_code = 5'd10; bd_m = 1; pc_m = 32'h0000_3008;
        step();
        exc_valid = 0; bd_m = 0;
        rd(5'd14, d); chk("exc_epc", d, 32'h0000_3004);
        rd(5'd13, d); chk("exc_cause", d, 32'h8000_0028);
        rd(5'd12, d); chk("exc_sr", d, 32'h0000_0002);
        watch_seq("exc", 3, 32'h0000_4180);

        // ---------------- interrupt beats exception; events in FLUSH ignored
        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001; exc_valid = 1; exc_code = 5'd4; pc_m = 32'h0000_2000;
        step();
        exc_code = 5'd12; pc_m = 32'h0000_5000;
        cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_7777;
        rd(5'd13, d); chk("arb_cause", d, 32'h0000_0400);
        step();
        cp0_we = 0; exc_valid = 0; hwint = '0;
        chk("arb_epc_hold", epc_out, 32'h0000_2000);
        watch_seq("arb", 2, 32'h0000_4180);
        rd(5'd14, d); chk("arb_epc_after", d, 32'h0000_2000);

        // ---------------- eret ----------------
        mtc0(5'd14, 32'h0000_3010);
        eret_m = 1;
        step();
        eret_m = 0;
        rd(5'd12, d); chk("eret_sr", d, 32'h0000_0401);
        watch_seq("eret", 3, 32'h0000_3010);

        // ---------------- exception dropped while EXL=1 ----------------
        mtc0(5'd12, 32'h0000_0002);
        exc_valid = 1; exc_code = 5'd8; pc_m = 32'h0000_6000;
        step();
        exc_valid = 0;
        chk("drop_busy", {31'b0, busy}, 32'd0);
        chk("drop_flush", {31'b0, flush}, 32'd0);
        chk("drop_epc", epc_out, 32'h0000_3010);

        // ---------------- mtc0 discarded on take ----------------
        mtc0(5'd12, 32'h0000_0000);
        exc_valid = 1; exc_code = 5'd2; pc_m = 32'h0000_7000;
        cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_9990;
        step();
        exc_valid = 0; cp0_we = 0;
        chk("mtc0take_epc", epc_out, 32'h0000_7000);
        watch_seq("mtc0take", 3, 32'h0000_4180);

        // ---------------- reset in mid-FLUSH ----------------
        mtc0(5'd12, 32'h0000_0000);
        exc_valid = 1; exc_code = 5'd3; pc_m = 32'h0000_8000;
        step();
        exc_valid = 0;
        chk("rstmid_flush_before", {31'b0, flush}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_flush", {31'b0, flush}, 32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_epc", epc_out, 32'd0);
        step();
        reset = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (redirect_valid || flush) seen++;
            end
            chk("rstmid_no_redirect", 32'(seen), 32'd0);
        end

`ifdef EXC_COUNT_EN
        // ---------------- event counter ----------------
        rd(5'd16, d); chk("cnt_reset", d, 32'd0);
        exc_valid = 1; exc_code = 5'd4; pc_m = 32'h0000_0100;
        step();
        exc_valid = 0;
        watch_seq("cnt1", 3, 32'h0000_4180);
        mtc0(5'd12, 32'h0000_0000);
        exc_valid = 1;
        step();
        exc_valid = 0;
        watch_seq("cnt2", 3, 32'h0000_4180);
        rd(5'd16, d); chk("cnt_two", d, 32'd2);
        mtc0(5'd16, 32'h0000_0000);
        rd(5'd16, d); chk("cnt_clear", d, 32'd0);
`else
        rd(5'd16, d); chk("cnt_absent", d, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
